// File: rtl/ifetch_unit.sv
// Instruction-fetch initiator: issues imem reads, buffers returned words in a
// small FIFO, and presents them to decode with redirect and end-marker halt.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        memrq,
    output logic        rnw,
    output logic [31:0] pc,
    input  logic [31:0] data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        halted
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [31:0]        buf_instr_q [DEPTH];
    logic [31:0]        buf_instr_d [DEPTH];
    logic [31:0]        buf_pc_q    [DEPTH];
    logic [31:0]        buf_pc_d    [DEPTH];

    logic               pop;
    logic               push;
    logic               flush;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; redirect is ignored while in BOOT
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (redirect) begin
                    state_d = RUN;
                end else if (memrq && (data == 32'h0)) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                if (redirect) begin
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // Output logic
    always_comb begin
        instr_valid = (count_q != '0);
        pop         = instr_valid & instr_ready;
        memrq       = (state_q == RUN) & ~redirect &
                      ((count_q < CNT_W'(DEPTH)) | pop);
        rnw         = 1'b1;
        pc          = fetch_pc_q;
        instr       = buf_instr_q[rd_ptr_q];
        instr_pc    = buf_pc_q[rd_ptr_q];
        halted      = (state_q == HALT) & (count_q == '0);
    end

    // Fetch PC and FIFO datapath
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        flush       = (state_q != BOOT) & redirect;
        push        = memrq & (data != 32'h0);

        if (flush) begin
            fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (push) begin
                buf_instr_d[wr_ptr_q] = data;
                buf_pc_d[wr_ptr_q]    = fetch_pc_q;
                wr_ptr_d              = wr_ptr_q + PTR_W'(1);
                fetch_pc_d            = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Buffer storage needs no reset; count gates visibility
    always_ff @(posedge clk) begin
        buf_instr_q <= buf_instr_d;
        buf_pc_q    <= buf_pc_d;
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized bench for ifetch_unit against a queue-based fetch/decode model.
module tb_ifetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int unsigned DEPTH  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memrq, rnw;
    logic [31:0] pc, data;
    logic        instr_valid;
    logic [31:0] instr, instr_pc;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halted;

    logic [31:0] mem [1024];

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Model: 0 = boot, 1 = fetching, 2 = halted
    int          m_state;
    logic [31:0] m_pc;
    logic [63:0] m_q [$];
    bit          m_init = 1'b0;

    assign data = mem[pc[11:2]];

    always #5 clk = ~clk;

    ifetch_unit #(
        .RESET_PC(RST_PC),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .memrq(memrq),
        .rnw(rnw),
        .pc(pc),
        .data(data),
        .instr_valid(instr_valid),
        .instr(instr),
        .instr_pc(instr_pc),
        .instr_ready(instr_ready),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .halted(halted)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs against the model, advance the model.
    task automatic step(input bit rdy, input bit rd, input logic [31:0] rpc, input bit rst);
        bit          e_valid, e_pop, e_memrq;
        logic [31:0] fetched;
        @(negedge clk);
        instr_ready = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        reset       = rst;
        #1;
        e_valid = (m_q.size() != 0);
        e_pop   = e_valid && rdy;
        e_memrq = (m_state == 1) && !rd && ((m_q.size() < DEPTH) || e_pop);
        if (m_init) begin
            check_eq("memrq", {31'b0, memrq}, {31'b0, e_memrq});
            check_eq("rnw", {31'b0, rnw}, 32'd1);
            check_eq("pc", pc, m_pc);
            check_eq("instr_valid", {31'b0, instr_valid}, {31'b0, e_valid});
            check_eq("halted", {31'b0, halted}, {31'b0, (m_state == 2) && !e_valid});
            if (e_valid) begin
                check_eq("instr", instr, m_q[0][63:32]);
                check_eq("instr_pc", instr_pc, m_q[0][31:0]);
            end
        end
        fetched = mem[m_pc[11:2]];
        @(posedge clk);
        if (rst) begin
            m_state = 0;
            m_pc    = RST_PC;
            m_q.delete();
            m_init  = 1'b1;
        end else begin
            if (e_pop) void'(m_q.pop_front());
            if (m_state == 0) begin
                m_state = 1;
            end else if (rd) begin
                m_q.delete();
                m_pc    = {rpc[31:2], 2'b00};
                m_state = 1;
            end else if (e_memrq) begin
                if (fetched != 32'h0) begin
                    m_q.push_back({fetched, m_pc});
                    m_pc = m_pc + 32'd4;
                end else begin
                    m_state = 2;
                end
            end
        end
    endtask

    initial begin
        logic [31:0] w;
        for (int i = 0; i < 1024; i++) begin
            w = $urandom;
            mem[i] = (w == 32'h0) ? 32'h0000_0013 : w;
        end
        mem[0]  = 32'h0080_0313;
        mem[9]  = 32'h0;
        mem[72] = 32'h00f0_0e13;

        // Stream from reset to the end marker, then resume by redirect from HALT
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        for (int i = 0; i < 16; i++) step(1, 0, 0, 0);
        step(1, 1, 32'h123, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);

        // Backpressure from reset, release, then redirect while full
        step(0, 0, 0, 1);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0);
        for (int i = 0; i < 2; i++) step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        step(0, 1, 32'h120, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);

        // Redirect with a same-cycle pop, then reset while full
        step(1, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        step(1, 1, 32'h40, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);

        // Scatter end markers above the start region for random runs
        for (int i = 0; i < 12; i++) mem[$urandom_range(16, 1023)] = 32'h0;

        for (int i = 0; i < 3000; i++) begin
            bit          rd;
            logic [31:0] rpc;
            rd  = ($urandom_range(0, 15) == 0);
            rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : 32'($urandom_range(0, 32'h1FF));
            step($urandom_range(0, 3) != 0, rd, rpc, $urandom_range(0, 199) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch initiator for the single-cycle/seq datapath. It drives read requests into the instruction memory and buffers the returned words in a small FIFO.
- It presents instructions to decode with a valid/ready handshake.
- It handles branch/jump redirects, and halts on an all-zero instruction word, which is the program end marker.

Parameters:
RESET_PC, 32'h0000_0000, PC of first fetch after reset (word aligned)
DEPTH, 2, instruction buffer entries (power of two, >=2)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
memrq  output  1  memory request strobe to imem
rnw  output  1  read-not-write to imem; constant 1
pc  output  32  fetch address to imem (byte address, [1:0]=0)
data  input  32  imem read data, combinational, valid in the same cycle memrq&rnw is high; this block never drives the bus
instr_valid  output  1  buffer head holds an instruction
instr  output  32  head instruction
instr_pc  output  32  byte PC of head instruction
instr_ready  input  1  decode accepts head this cycle
redirect  input  1  branch/jump taken; flush and refetch
redirect_pc  input  32  new fetch PC; bits [1:0] forced to 0
halted  output  1  HALT state and buffer empty

Behaviour:
- Reset values (reset high at posedge): state=BOOT, fetch_pc=RESET_PC, count=0, memrq=0, rnw=1, instr_valid=0, halted=0. instr/instr_pc are don't-care while instr_valid=0.
- Reset mid-operation discards all buffered entries and any in-flight state.
- States and transitions:
  - BOOT: one idle cycle after reset deasserts, giving imem time to finish its reset-time load. Next state is RUN.
  - RUN: fetching.
  - HALT: end marker fetched; no further requests.
- pc output = fetch_pc at all times. rnw = 1 at all times.
- memrq = (state==RUN) & !redirect & (count<DEPTH | pop).
  - pop = instr_valid & instr_ready.
- On a posedge with memrq=1:
  - data != 32'h0: push {data, fetch_pc} into the FIFO; fetch_pc <= fetch_pc+4.
  - data == 32'h0: no push, fetch_pc unchanged, state <= HALT.
- fetch_pc increments modulo 2^32 (0xFFFF_FFFC -> 0). imem aliases addresses above 0xFFC; this block does not check.
- FIFO:
  - instr_valid = (count!=0); instr/instr_pc come from the head entry.
  - Push and pop in the same cycle are allowed, including when full; count is unchanged in that case.
  - Count stays within 0..DEPTH.
- Latency: a word fetched at cycle N appears at the head at cycle N+1 if the buffer was empty.
- From reset deassert with instr_ready=1: the first instr_valid occurs 2 cycles after the BOOT cycle, then throughput is 1 instruction/cycle.
- Redirect (highest priority, any state except BOOT):
  - Same cycle: memrq=0.
  - At posedge: FIFO flushed (count<=0), fetch_pc <= {redirect_pc[31:2],2'b00}, state <= RUN.
  - A pop in the redirect cycle still completes the handshake for the current head; all other entries are discarded.
  - Redirect in HALT resumes fetching.
  - Redirect during BOOT is ignored.
- HALT: memrq=0. The buffer drains normally. halted=1 once count==0. Leaves HALT only via redirect or reset.
- Backpressure: with instr_ready=0 and count==DEPTH, memrq=0 and fetch_pc holds; the head is stable (instr/instr_pc do not change while instr_valid & !instr_ready).

Test Plan:
- Stream from reset: imem program loaded, instr_ready=1 → memrq rises after BOOT; instr_pc sequence 0x00,0x04,…,0x20 with one instr per cycle; first instr = the `addi t1,zero,8` encoding.
- End marker: same program, mem[9]=0 → exactly 9 instructions delivered (pc 0x00–0x20), memrq stays 0 after the 0x24 fetch, halted=1 one cycle after the last pop, no zero word ever presented.
- Backpressure: instr_ready=0 from reset → exactly DEPTH=2 fetches (pc 0x00,0x04), then memrq=0, pc=0x08 held, instr_pc=0x00 stable. Release ready → resumes at 0x08 with no loss or duplication.
- Redirect while full: buffer holds pc 0x10,0x14; redirect=1, redirect_pc=0x120 → memrq=0 that cycle, next cycle pc=0x120, next delivered instr_pc=0x120 (mem[72], `addi t3,zero,0xf`); 0x10/0x14 never delivered.
- Redirect + pop same cycle, and redirect from HALT: head 0x08 accepted in the redirect cycle, 0x0C dropped. Redirect_pc=0x123 from HALT → fetch resumes at 0x120, halted deasserts.
- Reset mid-run: assert reset with count=2 → next cycle instr_valid=0, memrq=0, pc=RESET_PC; sequence restarts at 0x00 after BOOT.
